// File: rtl/point_writer.sv
// Packs scanned 3D points into 36-bit ZBT0 words at sequential addresses from 0.
// Define POINT_WRITER_CLEAR_EN to zero-fill the buffer before each frame.
module point_writer #(
    parameter logic [18:0] LAST_ADDR = 19'h7FFFF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        frame_start,
    input  logic        frame_end,
    input  logic        point_valid,
    input  logic [9:0]  point_x,
    input  logic [9:0]  point_y,
    input  logic [9:0]  point_z,
    output logic        point_ready,
    output logic [18:0] zbt0_write_addr,
    output logic [35:0] zbt0_write_data,
    output logic        zbt0_we,
    output logic        busy,
    output logic        frame_done,
    output logic [18:0] point_count,
    output logic        overflow
);

    typedef enum logic [1:0] {StIdle, StClear, StAccept, StDone} state_e;

    // One extra bit so the counter can sit one past LAST_ADDR to flag a full buffer
    localparam logic [19:0] LastCnt = {1'b0, LAST_ADDR};

    state_e      state_q, state_d;
    logic [19:0] cnt_q, cnt_d;
    logic [18:0] addr_q, addr_d;
    logic [35:0] data_q, data_d;
    logic        we_q, we_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [18:0] count_q, count_d;
    logic        ovf_q, ovf_d;
    logic        full;
    logic        handshake;

    assign full      = cnt_q > LastCnt;
    assign handshake = point_valid & point_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (frame_start) begin
`ifdef POINT_WRITER_CLEAR_EN
                    state_d = StClear;
`else
                    state_d = StAccept;
`endif
                end
            end
`ifdef POINT_WRITER_CLEAR_EN
            StClear:  if (full) state_d = StAccept;
`endif
            StAccept: if (frame_end) state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        point_ready = (state_q == StAccept) && !full;
    end

    always_comb begin
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        busy_d  = (state_d != StIdle);
        unique case (state_q)
            StIdle: begin
                if (frame_start) begin
                    ovf_d   = 1'b0;
                    count_d = '0;
`ifdef POINT_WRITER_CLEAR_EN
                    // Issue the first clear write straight away so the pass is LAST_ADDR+1 cycles
                    we_d    = 1'b1;
                    addr_d  = '0;
                    data_d  = '0;
                    cnt_d   = 20'd1;
`else
                    cnt_d   = '0;
`endif
                end
            end
`ifdef POINT_WRITER_CLEAR_EN
            StClear: begin
                if (!full) begin
                    we_d   = 1'b1;
                    addr_d = cnt_q[18:0];
                    data_d = '0;
                    cnt_d  = cnt_q + 20'd1;
                end else begin
                    cnt_d  = '0;
                end
            end
`endif
            StAccept: begin
                if (handshake) begin
                    we_d    = 1'b1;
                    addr_d  = cnt_q[18:0];
                    data_d  = {6'b0, point_x, point_y, point_z};
                    cnt_d   = cnt_q + 20'd1;
                    count_d = count_q + 19'd1;
                end
                if (point_valid && full) ovf_d = 1'b1;
                if (frame_end) done_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign zbt0_we         = we_q;
    assign zbt0_write_addr = addr_q;
    assign zbt0_write_data = data_q;
    assign busy            = busy_q;
    assign frame_done      = done_q;
    assign point_count     = count_q;
    assign overflow        = ovf_q;

endmodule
